// File: rtl/sel_pipe_mux_pkg.sv
// Shared definitions for the sel_pipe_mux slice.
//   - state_t     : occupancy state of the output pipeline (main + skid register)
//   - DEF_WIDTH   : default data width per channel
//   - DEF_N       : default channel count
package sel_pipe_mux_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_N     = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

endpackage

// File: rtl/sel_pipe_mux_core.sv
// Combinational channel select with zero forcing and out-of-range detection.
//   i_din     : N flattened channels, channel k at [k*WIDTH +: WIDTH]
//   i_sel     : channel select
//   i_zero_en : force data to zero
//   o_data    : selected word (0 if zeroed, DEFAULT_VAL if out of range)
//   o_oob     : select is >= N
module sel_pipe_mux_core
  import sel_pipe_mux_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      N           = DEF_N,
  parameter int unsigned      SEL_W       = 5,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic [N*WIDTH-1:0] i_din,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic               i_zero_en,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_oob
);

  logic [31:0]      w_sel_ext;
  logic [WIDTH-1:0] w_chan;

  assign w_sel_ext = 32'(i_sel);

  always_comb begin
    w_chan = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_sel_ext == k) begin
        w_chan = i_din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    o_oob  = (w_sel_ext >= N);
    o_data = w_chan;
    if (i_zero_en) begin
      o_data = '0;
    end else if (o_oob) begin
      o_data = DEFAULT_VAL;
    end
  end

endmodule

// File: rtl/sel_pipe_mux.sv
// Registered channel multiplexer with a ready/valid skid buffer.
//   clk, reset  : clock, synchronous active-low reset
//   din, sel, zero_en, in_valid / in_ready : upstream handshake and payload
//   out_valid / out_ready                  : downstream handshake
//   out_data, out_sel, out_oob             : held result (selected word, its select,
//                                            out-of-range flag)
module sel_pipe_mux
  import sel_pipe_mux_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      N           = DEF_N,
  parameter int unsigned      SEL_W       = 5,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               zero_en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_oob
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;

  logic [WIDTH-1:0] r_main_data, r_skid_data;
  logic [SEL_W-1:0] r_main_sel,  r_skid_sel;
  logic             r_main_oob,  r_skid_oob;

  logic [WIDTH-1:0] w_cap_data;
  logic             w_cap_oob;
  logic             w_accept;
  logic             w_consume;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  sel_pipe_mux_core #(
    .WIDTH       (WIDTH),
    .N           (N),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_core (
    .i_din     (din),
    .i_sel     (sel),
    .i_zero_en (zero_en),
    .o_data    (w_cap_data),
    .o_oob     (w_cap_oob)
  );

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = (r_state != EMPTY) & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_main = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_consume) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
        end else if (!w_accept && w_consume) begin
          w_state_nxt = EMPTY;
        end else if (w_accept && w_consume) begin
          w_load_main = 1'b1;
        end
      end
      TWO: begin
        if (w_consume) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it never follows out_ready
  // combinationally; TWO is the only state that cannot take another word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_main_oob  <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_oob  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
      if (w_load_main) begin
        r_main_data <= w_cap_data;
        r_main_sel  <= sel;
        r_main_oob  <= w_cap_oob;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_sel  <= r_skid_sel;
        r_main_oob  <= r_skid_oob;
      end
      if (w_load_skid) begin
        r_skid_data <= w_cap_data;
        r_skid_sel  <= sel;
        r_skid_oob  <= w_cap_oob;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;
  assign out_oob   = r_main_oob;

endmodule

// File: tb/tb_sel_pipe_mux.sv
module tb_sel_pipe_mux;

  localparam int unsigned W    = 32;
  localparam int unsigned NCH  = 32;
  localparam int unsigned SW   = 5;
  localparam logic [31:0] DEF3 = 32'hA5A5_0F0F;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          oob;
  } word_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*W-1:0]  din;
  logic [SW-1:0]     sel;
  logic              zero_en;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_sel;
  logic              out_oob;

  logic [3*W-1:0]    din3;
  logic [1:0]        sel3;
  logic              zero_en3;
  logic              in_valid3;
  logic              in_ready3;
  logic              out_valid3;
  logic              out_ready3;
  logic [W-1:0]      out_data3;
  logic [1:0]        out_sel3;
  logic              out_oob3;

  word_t             q[$];
  logic [W-1:0]      obs[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_dut_cons = 0;

  always #5 clk = ~clk;

  sel_pipe_mux #(
    .WIDTH (W), .N (NCH), .SEL_W (SW), .DEFAULT_VAL (32'h0)
  ) u_dut (
    .clk (clk), .reset (reset), .din (din), .sel (sel), .zero_en (zero_en),
    .in_valid (in_valid), .in_ready (in_ready), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .out_sel (out_sel), .out_oob (out_oob)
  );

  sel_pipe_mux #(
    .WIDTH (W), .N (3), .SEL_W (2), .DEFAULT_VAL (DEF3)
  ) u_dut3 (
    .clk (clk), .reset (reset), .din (din3), .sel (sel3), .zero_en (zero_en3),
    .in_valid (in_valid3), .in_ready (in_ready3), .out_valid (out_valid3),
    .out_ready (out_ready3), .out_data (out_data3), .out_sel (out_sel3), .out_oob (out_oob3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t ref_word(input logic [NCH*W-1:0] d, input logic [SW-1:0] s,
                                     input logic ze);
    word_t       w;
    int unsigned idx;
    idx    = int'(s);
    w.sel  = s;
    w.oob  = (idx >= NCH);
    if (ze)         w.data = '0;
    else if (w.oob) w.data = '0;
    else            w.data = d[idx*W +: W];
    return w;
  endfunction

  function automatic logic [NCH*W-1:0] rand_din();
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  task automatic compare_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].data));
      chk("out_sel",  64'(out_sel),  64'(q[0].sel));
      chk("out_oob",  64'(out_oob),  64'(q[0].oob));
    end
  endtask

  // One clock of the main DUT: drive, predict, advance, compare.
  task automatic step(input logic rn, input logic iv, input logic [SW-1:0] s,
                      input logic ze, input logic ordy, input logic [NCH*W-1:0] d);
    logic acc, cons;
    reset     = rn;
    in_valid  = iv;
    sel       = s;
    zero_en   = ze;
    out_ready = ordy;
    din       = d;
    acc  = rn && iv && (q.size() < 2);
    cons = rn && ordy && (q.size() != 0);
    if (rn && out_valid && ordy) begin
      n_dut_cons++;
      obs.push_back(out_data);
    end
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc)  q.push_back(ref_word(d, s, ze));
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() != 0; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, din);
  endtask

  initial begin
    logic [NCH*W-1:0] d;
    int               k;
    int               cyc;

    reset = 1'b0; din = '0; sel = '0; zero_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din3 = '0; sel3 = '0; zero_en3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;

    // Reset state
    step(1'b0, 1'b1, 5'd3, 1'b0, 1'b1, rand_din());
    step(1'b0, 1'b1, 5'd4, 1'b0, 1'b1, rand_din());
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_sel",   64'(out_sel),   64'd0);
    chk("rst_out_oob",   64'(out_oob),   64'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, rand_din());

    // Out-of-range select on a 3-channel instance
    din3 = {32'h3333_2222, 32'h2222_1111, 32'h1111_0000};
    sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("n3_valid", 64'(out_valid3), 64'd1);
    chk("n3_oob_data", 64'(out_data3), 64'(DEF3));
    chk("n3_oob_flag", 64'(out_oob3), 64'd1);
    chk("n3_oob_sel", 64'(out_sel3), 64'd3);
    sel3 = 2'd2;
    @(posedge clk); @(negedge clk);
    chk("n3_ch2_data", 64'(out_data3), 64'h3333_2222);
    chk("n3_ch2_oob", 64'(out_oob3), 64'd0);
    in_valid3 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("n3_drained", 64'(out_valid3), 64'd0);
    compare_all();

    // Single word, channel 5
    d = rand_din();
    d[5*W +: W] = 32'hDEADBEEF;
    step(1'b1, 1'b1, 5'd5, 1'b0, 1'b1, d);
    chk("ch5_valid", 64'(out_valid), 64'd1);
    chk("ch5_data",  64'(out_data),  64'hDEADBEEF);
    chk("ch5_sel",   64'(out_sel),   64'd5);
    chk("ch5_oob",   64'(out_oob),   64'd0);
    drain();

    // zero_en overrides the channel
    d = rand_din();
    d[7*W +: W] = 32'h0000_1234;
    step(1'b1, 1'b1, 5'd7, 1'b1, 1'b1, d);
    chk("zero_data", 64'(out_data), 64'd0);
    chk("zero_sel",  64'(out_sel),  64'd7);
    drain();

    // Stream 0..9 with a stall on cycles 2-4
    for (int j = 0; j < NCH; j++) d[j*W +: W] = 32'(j + 32'h100);
    obs.delete();
    k = 0; cyc = 0;
    while (k < 10 && cyc < 40) begin
      logic can_acc;
      can_acc = (q.size() < 2);
      step(1'b1, 1'b1, SW'(k), 1'b0, !(cyc >= 2 && cyc <= 4), d);
      if (can_acc) k++;
      cyc++;
    end
    chk("stream_accepted", 64'(k), 64'd10);
    drain();
    chk("stream_count", 64'(obs.size()), 64'd10);
    for (int i = 0; i < obs.size() && i < 10; i++) chk("stream_order", 64'(obs[i]), 64'(32'h100 + i));

    // 16 back-to-back words with out_ready held high
    n_dut_cons = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b1, rand_din());
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, din);
    chk("b2b_consumes", 64'(n_dut_cons), 64'd16);

    // Reset while holding two words
    step(1'b1, 1'b1, 5'd1, 1'b0, 1'b0, rand_din());
    step(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, rand_din());
    chk("two_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, rand_din());
    chk("midrst_valid",    64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready),  64'd1);
    d = rand_din();
    step(1'b1, 1'b1, 5'd9, 1'b0, 1'b1, d);
    chk("postrst_data", 64'(out_data), 64'(d[9*W +: W]));
    chk("postrst_sel",  64'(out_sel),  64'd9);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), SW'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) < 3), rand_din());
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
